// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Also holds the opcode constants recognised by the decode stage.
package mips_ctrl_pkg;

  localparam int OPW = 6;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OPW-1:0] RTYPE = 6'h00;
  localparam logic [OPW-1:0] J     = 6'h02;
  localparam logic [OPW-1:0] BEQ   = 6'h04;
  localparam logic [OPW-1:0] BNE   = 6'h05;
  localparam logic [OPW-1:0] ADDI  = 6'h08;
  localparam logic [OPW-1:0] LW    = 6'h23;
  localparam logic [OPW-1:0] SW    = 6'h2B;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_supported(input logic [OPW-1:0] op);
    logic ok;
    case (op)
      RTYPE, J, BEQ, BNE, ADDI, LW, SW: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OPW-1:0] Op;
  logic           Zero;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           RegDst;
  logic           MemtoReg;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUOp;
  logic [1:0]     PCSrc;
  logic           PCEn;
  logic           IllegalOp;

  modport master (
    input  Op, Zero,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
  );

  modport slave (
    output Op, Zero,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp
  );

endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: Moore decode of every
// select and write enable, plus branch-qualified PC enable and illegal-op flag.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  state_t     state_r;
  state_t     state_next_s;
  logic       bne_r;
  logic       illegal_r;

  logic       iord_s;
  logic       memread_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;
  logic [1:0] pcsrc_s;
  logic       pcen_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Branch sense and sticky illegal flag, both captured while decoding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bne_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      bne_r     <= (bus.Op == BNE);
      illegal_r <= illegal_r | ~op_supported(bus.Op);
    end else begin
      bne_r     <= bne_r;
      illegal_r <= illegal_r;
    end
  end

  // Next-state sequencing per opcode class.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:    state_next_s = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          LW, SW:   state_next_s = S_MEMADR;
          RTYPE:    state_next_s = S_EXECUTE;
          BEQ, BNE: state_next_s = S_BRANCH;
          ADDI:     state_next_s = S_ADDIEXEC;
          J:        state_next_s = S_JUMP;
          default:  state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Op == LW) begin
          state_next_s = S_MEMRD;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_MEMRD:    state_next_s = S_MEMWB;
      S_EXECUTE:  state_next_s = S_ALUWB;
      S_ADDIEXEC: state_next_s = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                  state_next_s = S_FETCH;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // Output decode; only the branch PC enable looks past the state.
  always_comb begin
    iord_s     = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = ALUSRCB_B;
    aluop_s    = ALUOP_ADD;
    pcsrc_s    = PCSRC_ALURES;
    pcen_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        memread_s = 1'b1;
        irwrite_s = 1'b1;
        alusrcb_s = ALUSRCB_FOUR;
        pcsrc_s   = PCSRC_ALURES;
        pcen_s    = 1'b1;
      end
      S_DECODE:   alusrcb_s = ALUSRCB_IMMSH;
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        iord_s    = 1'b1;
        memread_s = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = PCSRC_ALUOUT;
        pcen_s    = bus.Zero ^ bne_r;
      end
      S_ADDIEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = ALUSRCB_IMM;
      end
      S_ADDIWB:   regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc_s = PCSRC_JUMP;
        pcen_s  = 1'b1;
      end
      default: begin
        pcen_s = 1'b0;
      end
    endcase
  end

  // Write strobes are held off for as long as reset is high.
  assign bus.IorD      = iord_s;
  assign bus.MemRead   = memread_s;
  assign bus.MemWrite  = memwrite_s & ~reset;
  assign bus.IRWrite   = irwrite_s & ~reset;
  assign bus.RegDst    = regdst_s;
  assign bus.MemtoReg  = memtoreg_s;
  assign bus.RegWrite  = regwrite_s & ~reset;
  assign bus.ALUSrcA   = alusrca_s;
  assign bus.ALUSrcB   = alusrcb_s;
  assign bus.ALUOp     = aluop_s;
  assign bus.PCSrc     = pcsrc_s;
  assign bus.PCEn      = pcen_s & ~reset;
  assign bus.IllegalOp = illegal_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction control traces
// predicted from opcode class and cycle index, with randomized op mixes.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic illegal_m = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn}
  function automatic logic [14:0] dut_word();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSrc, bus.PCEn};
  endfunction

  function automatic int instr_len(logic [5:0] op);
    if (op == 6'h23) return 5;
    if (op == 6'h2B || op == 6'h00 || op == 6'h08) return 4;
    if (op == 6'h04 || op == 6'h05 || op == 6'h02) return 3;
    return 2;
  endfunction

  // Expected controls for cycle c (0 = fetch) of an instruction with opcode op.
  function automatic logic [14:0] exp_word(logic [5:0] op, int c, logic z);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, asa, pce;
    logic [1:0] asb, aop, pcs;
    {iord, mrd, mwr, irw, rdst, m2r, rw, asa, pce} = 9'b0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (c == 0) begin
      mrd = 1'b1; irw = 1'b1; asb = 2'b01; pce = 1'b1;
    end else if (c == 1) begin
      asb = 2'b11;
    end else if (op == 6'h23 || op == 6'h2B) begin
      if (c == 2) begin asa = 1'b1; asb = 2'b10; end
      else if (op == 6'h2B) begin iord = 1'b1; mwr = 1'b1; end
      else if (c == 3) begin iord = 1'b1; mrd = 1'b1; end
      else begin m2r = 1'b1; rw = 1'b1; end
    end else if (op == 6'h00) begin
      if (c == 2) begin asa = 1'b1; aop = 2'b10; end
      else begin rdst = 1'b1; rw = 1'b1; end
    end else if (op == 6'h08) begin
      if (c == 2) begin asa = 1'b1; asb = 2'b10; end
      else rw = 1'b1;
    end else if (op == 6'h04 || op == 6'h05) begin
      asa = 1'b1; aop = 2'b01; pcs = 2'b01;
      pce = (op == 6'h04) ? z : ~z;
    end else if (op == 6'h02) begin
      pcs = 2'b10; pce = 1'b1;
    end
    return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pce};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [8];
    tbl = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  task automatic test_reset();
    logic [14:0] w;
    reset = 1'b1; bus.Op = 6'h00; bus.Zero = 1'b0;
    repeat (2) @(negedge clk);
    w = exp_word(6'h00, 0, 1'b0); w[11] = 1'b0; w[0] = 1'b0;
    vectors++;
    if (dut_word() !== w) begin miscompares++;
      $display("FAIL reset_hold got=%h want=%h", dut_word(), w); end
    vectors++;
    if (bus.IllegalOp !== 1'b0) begin miscompares++;
      $display("FAIL reset_illegal got=%b want=0", bus.IllegalOp); end
    reset = 1'b0; #1;
    vectors++;
    if (dut_word() !== exp_word(6'h00, 0, 1'b0)) begin miscompares++;
      $display("FAIL reset_first_fetch got=%h want=%h", dut_word(), exp_word(6'h00, 0, 1'b0)); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      vectors++;
      if (dut_word() !== exp_word(6'h00, c, 1'b0)) begin miscompares++;
        $display("FAIL reset_rtype c=%0d got=%h want=%h", c, dut_word(), exp_word(6'h00, c, 1'b0)); end
    end
    // Abort in the middle of EXECUTE.
    reset = 1'b1; #1;
    vectors++;
    if (dut_word() !== w || bus.PCSrc !== 2'b00) begin miscompares++;
      $display("FAIL reset_abort got=%h want=%h", dut_word(), w); end
    @(negedge clk);
    reset = 1'b0; #1;
    vectors++;
    if (dut_word() !== exp_word(6'h00, 0, 1'b0)) begin miscompares++;
      $display("FAIL reset_refetch got=%h want=%h", dut_word(), exp_word(6'h00, 0, 1'b0)); end
    illegal_m = 1'b0;
  endtask

  task automatic test_directed();
    logic [5:0] ops [10];
    logic       zs  [10];
    logic [5:0] op;
    ops = '{6'h23, 6'h04, 6'h04, 6'h05, 6'h05, 6'h02, 6'h2B, 6'h08, 6'h00, 6'h23};
    zs  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    for (int i = 0; i < 10; i++) begin
      op = ops[i];
      bus.Zero = zs[i];
      for (int c = 0; c < instr_len(op); c++) begin
        vectors++;
        if (dut_word() !== exp_word(op, c, zs[i])) begin miscompares++;
          $display("FAIL directed op=%h c=%0d got=%h want=%h", op, c, dut_word(), exp_word(op, c, zs[i])); end
        vectors++;
        if (bus.IllegalOp !== illegal_m) begin miscompares++;
          $display("FAIL directed_illegal op=%h got=%b want=%b", op, bus.IllegalOp, illegal_m); end
        if (c == 0) bus.Op = op;
        else if (c >= ((op == 6'h23 || op == 6'h2B) ? 3 : 2)) bus.Op = 6'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    logic [5:0] op;
    ops = '{6'h3F, 6'h00};
    for (int i = 0; i < 2; i++) begin
      op = ops[i];
      for (int c = 0; c < instr_len(op); c++) begin
        vectors++;
        if (dut_word() !== exp_word(op, c, 1'b0)) begin miscompares++;
          $display("FAIL illegal_seq op=%h c=%0d got=%h want=%h", op, c, dut_word(), exp_word(op, c, 1'b0)); end
        vectors++;
        if (bus.IllegalOp !== illegal_m) begin miscompares++;
          $display("FAIL illegal_flag op=%h c=%0d got=%b want=%b", op, c, bus.IllegalOp, illegal_m); end
        if (c == 0) bus.Op = op;
        if (c == 1 && !op_supported(op)) illegal_m = 1'b1;
        @(negedge clk);
      end
    end
    vectors++;
    if (dut_word() !== exp_word(6'h00, 0, 1'b0) || bus.IllegalOp !== 1'b1) begin miscompares++;
      $display("FAIL illegal_after got=%h/%b want=%h/1", dut_word(), bus.IllegalOp, exp_word(6'h00, 0, 1'b0)); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic       z;
    for (int i = 0; i < 300; i++) begin
      op = pick_op();
      z  = 1'($urandom);
      bus.Zero = z;
      for (int c = 0; c < instr_len(op); c++) begin
        vectors++;
        if (dut_word() !== exp_word(op, c, z)) begin miscompares++;
          $display("FAIL random op=%h c=%0d z=%b got=%h want=%h", op, c, z, dut_word(), exp_word(op, c, z)); end
        vectors++;
        if (bus.IllegalOp !== illegal_m || bus.PCSrc === 2'b11) begin miscompares++;
          $display("FAIL random_flag op=%h illegal=%b want=%b pcsrc=%b", op, bus.IllegalOp, illegal_m, bus.PCSrc); end
        if (c == 0) bus.Op = op;
        else if (c >= ((op == 6'h23 || op == 6'h2B) ? 3 : 2)) bus.Op = 6'($urandom);
        if (c == 1 && !op_supported(op)) illegal_m = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_clear();
    reset = 1'b1; #1;
    vectors++;
    if (bus.IllegalOp !== 1'b0) begin miscompares++;
      $display("FAIL reset_clear got=%b want=0", bus.IllegalOp); end
    @(negedge clk);
    reset = 1'b0;
    illegal_m = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_reset_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It drives every datapath select and write-enable, including the 2-bit PCSrc select consumed by the next-PC mux and the combined PC write enable. The FSM sequences fetch, decode, execute, memory and writeback per opcode and flags unsupported opcodes. It sits between the instruction register (opcode field) and ALU (Zero flag) on one side and all datapath muxes and registers on the other.

Parameters:
OPW, 6, opcode field width (fixed at 6 for MIPS-I; parameter kept for package consistency)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Op  input  6  IR[31:26]; stable from DECODE until the next FETCH
Zero  input  1  ALU zero flag, valid in the BRANCH state
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write register select: 0 = rt, 1 = rd
MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
ALUOp  output  2  ALU decoder class: 00 = add, 01 = sub, 10 = funct
PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target; 11 is never driven
PCEn  output  1  PC register write enable
IllegalOp  output  1  sticky unsupported-opcode flag

Behaviour:
- Moore FSM. The state register is updated on the rising edge of clk; all outputs decode combinationally from state only. Exception: PCEn also depends on Zero and the registered bne flag.
- Reset (asynchronous, reset=1):
  - State goes to FETCH; bne flag = 0; IllegalOp = 0.
  - While reset is high, PCEn, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs show their FETCH values.
- Defaults in every state: all 1-bit outputs 0, ALUSrcB = 00, ALUOp = 00, PCSrc = 00, unless the state lists otherwise.
- States and assertions:
  - FETCH: MemRead, IRWrite, ALUSrcB=01, PCSrc=00, PCEn=1. Next: DECODE.
  - DECODE: ALUSrcB=11 (branch target into ALUOut). Latch bne flag = (Op==BNE). Next state by Op:
    - LW or SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ or BNE -> BRANCH
    - ADDI -> ADDIEXEC
    - J -> JUMP
    - any other Op -> FETCH, and IllegalOp set to 1 (sticky until reset)
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Next: MEMRD if Op==LW, else MEMWR.
  - MEMRD: IorD=1, MemRead. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite. Next: FETCH.
  - MEMWR: IorD=1, MemWrite. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn = Zero XOR bne_flag. Next: FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite. Next: FETCH.
  - JUMP: PCSrc=10, PCEn=1. Next: FETCH.
- Cycles per instruction, FETCH inclusive:
  - LW 5
  - SW 4, RTYPE 4, ADDI 4
  - BEQ/BNE 3, J 3
  - illegal 2
- Reset asserted mid-instruction aborts immediately, with no further write strobes. The first FETCH runs in the first clock after reset deasserts.
- Unreachable state encodings (full-case default) go to FETCH with all outputs at their defaults.
- Op is not sampled outside DECODE and MEMADR.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode constants: RTYPE=6'h00, J=6'h02, BEQ=6'h04, BNE=6'h05, ADDI=6'h08, LW=6'h23, SW=6'h2B
  - PCSrc encodings: PCSRC_ALURES, PCSRC_ALUOUT, PCSRC_JUMP
  - ALUSrcB and ALUOp encodings
- No sub-module. The next-state logic and the output decoder are two always_comb blocks in one module.

Test Plan:
- Reset: assert reset mid-EXECUTE -> same cycle PCEn=0, RegWrite=0, PCSrc=00, IllegalOp=0. Deassert -> next edge state=DECODE, having asserted IRWrite=1 and PCEn=1 during FETCH.
- LW (Op=6'h23): exactly 5 cycles. Cycle 3 shows IorD=1, MemRead=1. Cycle 4 shows MemtoReg=1, RegWrite=1, RegDst=0. Cycle 5 is FETCH again.
- BEQ (Op=6'h04): BRANCH with Zero=1 -> PCSrc=01, PCEn=1. Repeat with Zero=0 -> PCEn=0. Each takes 3 cycles total.
- BNE (Op=6'h05): BRANCH with Zero=0 -> PCEn=1; with Zero=1 -> PCEn=0.
- J (Op=6'h02): JUMP state shows PCSrc=10, PCEn=1. No RegWrite or MemWrite at any cycle. Total 3 cycles.
- Illegal Op=6'h3F: DECODE -> FETCH in 2 cycles and IllegalOp=1. A following RTYPE runs normally in 4 cycles with IllegalOp still 1. PCSrc is never 11 during a random opcode sweep (assertion).
